// File: rtl/instr_encoder_loader.sv
// RV32 descriptor-to-word encoder that streams encoded instructions into imem at consecutive addresses.
// Latency: accept in cycle N gives mem_we with data in N+1. in_ready only in LOAD; WRITE holds until mem_ready.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [6:0]        in_funct7,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_IMM   = 2'd1;
    localparam logic [1:0] CODE_TYPE  = 2'd2;
    localparam logic [1:0] CODE_OVFL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              last_q, last_d;

    logic        accept;
    logic        restart;
    logic [31:0] enc_word;
    logic        imm12_ok;
    logic        imm13_ok;
    logic        bad_type;
    logic        bad_imm;
    logic [1:0]  chk_code;

    assign accept  = in_valid && (state_q == S_LOAD);
    assign restart = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Sign-extension checks: every bit above the encodable field must match the sign bit.
    assign imm12_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign imm13_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];

    always_comb begin
        enc_word = '0;
        bad_type = 1'b0;
        bad_imm  = 1'b0;
        case (in_type)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            3'd1: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
                bad_imm  = !imm12_ok;
            end
            3'd2: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_L};
                bad_imm  = !imm12_ok;
            end
            3'd3: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_S};
                bad_imm  = !imm12_ok;
            end
            3'd4: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OP_B};
                bad_imm  = !imm13_ok;
                bad_type = (in_funct3[2:1] != 2'b00);
            end
            default: bad_type = 1'b1;
        endcase
    end

    always_comb begin
        chk_code = CODE_NONE;
        if (bad_type) begin
            chk_code = CODE_TYPE;
        end else if (bad_imm) begin
            chk_code = CODE_IMM;
        end else if (word_count_q == FULL_COUNT) begin
            chk_code = CODE_OVFL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    state_d = (chk_code != CODE_NONE) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: if (mem_ready) state_d = last_q ? S_DONE : S_LOAD;
            S_DONE:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_LOAD);
        mem_we   = (state_q == S_WRITE);
        busy     = (state_q == S_LOAD) || (state_q == S_WRITE);
        done     = (state_q == S_DONE);
    end

    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        last_d       = last_q;
        if (restart) begin
            mem_addr_d   = BASE;
            word_count_d = '0;
            err_d        = 1'b0;
            err_code_d   = CODE_NONE;
        end else if (accept) begin
            if (chk_code != CODE_NONE) begin
                err_d      = 1'b1;
                err_code_d = chk_code;
            end else begin
                mem_wdata_d = enc_word;
                last_d      = in_last;
            end
        end else if ((state_q == S_WRITE) && mem_ready) begin
            mem_addr_d   = mem_addr_q + ADDR_W'(1);
            word_count_d = word_count_q + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q   <= BASE;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            err_code_q   <= CODE_NONE;
            last_q       <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            last_q       <= last_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: encoding table, multi-cycle sequences, random programs vs a reference model.
module tb_instr_encoder_loader;

    typedef struct packed {
        logic [2:0]  typ;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        last;
    } desc_t;

    typedef struct packed {
        desc_t       d;
        logic [31:0] word;
        logic [1:0]  code;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start2 = 1'b0, in_valid = 1'b0;
    logic [2:0]  in_type = '0;
    logic [6:0]  in_funct7 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        mem_ready_man = 1'b1, rnd_en = 1'b0, rnd_r = 1'b0;
    wire         mem_ready = rnd_en ? rnd_r : mem_ready_man;

    logic        in_ready1, mem_we1, busy1, done1, err1;
    logic [7:0]  mem_addr1;
    logic [31:0] wdata1;
    logic [1:0]  code1;
    logic [8:0]  wc1;

    logic        in_ready2, mem_we2, busy2, done2, err2;
    logic [1:0]  mem_addr2;
    logic [31:0] wdata2;
    logic [1:0]  code2;
    logic [2:0]  wc2;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    int          exp_addr_q [$];
    logic        mon_en = 1'b0;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(in_ready1),
        .in_type(in_type), .in_funct7(in_funct7), .in_funct3(in_funct3), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(wdata1), .mem_ready(mem_ready),
        .busy(busy1), .done(done1), .err(err1), .err_code(code1), .word_count(wc1)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_type(in_type), .in_funct7(in_funct7), .in_funct3(in_funct3), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(wdata2), .mem_ready(mem_ready),
        .busy(busy2), .done(done2), .err(err2), .err_code(code2), .word_count(wc2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        rnd_r = ($urandom_range(0, 2) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic desc_t mk(input logic [2:0] t, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] imm, input logic last);
        desc_t d;
        d.typ = t; d.f7 = f7; d.f3 = f3; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd;
        d.imm = imm; d.last = last;
        return d;
    endfunction

    // Legality from the numeric immediate range, not from bit patterns.
    function automatic logic [1:0] model_code(input desc_t d);
        int si;
        si = $signed(d.imm);
        if (d.typ > 3'd4) return 2'd2;
        if (d.typ == 3'd4 && d.f3 > 3'd1) return 2'd2;
        if ((d.typ >= 3'd1 && d.typ <= 3'd3) && (si < -2048 || si > 2047)) return 2'd1;
        if (d.typ == 3'd4 && (si < -4096 || si > 4095 || (si % 2) != 0)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_word(input desc_t d);
        logic [31:0] imm, f7, f3, rs1, rs2, rd;
        imm = d.imm; f7 = 32'(d.f7); f3 = 32'(d.f3);
        rs1 = 32'(d.rs1); rs2 = 32'(d.rs2); rd = 32'(d.rd);
        case (d.typ)
            3'd0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            3'd1: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            3'd2: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
            3'd3: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
                         | ((imm & 32'h1F) << 7) | 32'h23;
            default: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                         | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                         | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
        endcase
    endfunction

    function automatic desc_t gen();
        desc_t d;
        int r, si;
        r = $urandom_range(0, 19);
        d.typ = (r == 0) ? 3'($urandom_range(5, 7)) : 3'(r % 5);
        d.f7 = 7'($urandom); d.f3 = 3'($urandom);
        d.rs1 = 5'($urandom); d.rs2 = 5'($urandom); d.rd = 5'($urandom);
        if (d.typ == 3'd4 && $urandom_range(0, 3) != 0) d.f3 = 3'($urandom_range(0, 1));
        si = int'($urandom_range(0, 5000)) - 2500;
        if (d.typ == 3'd4) begin
            si = si * 2;
            if ($urandom_range(0, 7) == 0) si = si + 1;
        end
        d.imm = ($urandom_range(0, 9) == 0) ? $urandom : 32'(si);
        d.last = 1'b0;
        return d;
    endfunction

    always @(negedge clk) begin
        if (mon_en && mem_we1 && mem_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {32'd0, wdata1}, 64'hDEAD);
            end else begin
                chk("rnd_addr", 64'(mem_addr1), 64'(exp_addr_q.pop_front()));
                chk("rnd_wdata", 64'(wdata1), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic pulse(input bit sel);
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Returns #1 after the accepting clock edge.
    task automatic send(input desc_t d, input bit sel);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if ((sel ? in_ready2 : in_ready1) == 1'b1) begin
                in_type = d.typ; in_funct7 = d.f7; in_funct3 = d.f3;
                in_rs1 = d.rs1; in_rs2 = d.rs2; in_rd = d.rd;
                in_imm = d.imm; in_last = d.last; in_valid = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
    endtask

    task automatic wait_done(input bit sel);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if ((sel ? done2 : done1) == 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done stayed 0, expected 1 within 300 cycles");
        end
    endtask

    initial begin
        desc_t d;
        vt[0]  = '{mk(0, 7'h00, 0, 1, 2, 3, 32'd0, 1),          32'h002081B3, 2'd0};
        vt[1]  = '{mk(1, 7'h00, 0, 0, 31, 1, 32'd5, 1),         32'h00500093, 2'd0};
        vt[2]  = '{mk(2, 7'h55, 7, 2, 9, 5, 32'd8, 1),          32'h00812283, 2'd0};
        vt[3]  = '{mk(3, 7'h00, 7, 2, 5, 31, 32'd12, 1),        32'h00512623, 2'd0};
        vt[4]  = '{mk(4, 7'h00, 0, 1, 2, 0, 32'hFFFFFFF8, 1),   32'hFE208CE3, 2'd0};
        vt[5]  = '{mk(1, 7'h00, 7, 3, 0, 2, 32'hFFFFFFFF, 1),   32'hFFF1F113, 2'd0};
        vt[6]  = '{mk(1, 7'h00, 0, 1, 0, 1, 32'd2047, 1),       32'h7FF08093, 2'd0};
        vt[7]  = '{mk(3, 7'h00, 0, 4, 3, 0, 32'hFFFFF800, 1),   32'h80322023, 2'd0};
        vt[8]  = '{mk(4, 7'h00, 1, 5, 6, 0, 32'd4094, 1),       32'h7E629FE3, 2'd0};
        vt[9]  = '{mk(1, 7'h00, 0, 0, 0, 1, 32'd2048, 1),       32'h0, 2'd1};
        vt[10] = '{mk(2, 7'h00, 0, 0, 0, 1, 32'hFFFFF7FF, 1),   32'h0, 2'd1};
        vt[11] = '{mk(4, 7'h00, 4, 1, 2, 0, 32'd0, 1),          32'h0, 2'd2};
        vt[12] = '{mk(6, 7'h00, 0, 1, 2, 3, 32'd0, 1),          32'h0, 2'd2};
        vt[13] = '{mk(4, 7'h00, 0, 1, 2, 0, 32'd3, 1),          32'h0, 2'd1};
        vt[14] = '{mk(4, 7'h00, 0, 1, 2, 0, 32'd4096, 1),       32'h0, 2'd1};
        vt[15] = '{mk(4, 7'h00, 5, 1, 2, 0, 32'd3, 1),          32'h0, 2'd2};
        vt[16] = '{mk(5, 7'h00, 0, 1, 2, 3, 32'd0, 1),          32'h0, 2'd2};
        vt[17] = '{mk(3, 7'h00, 0, 1, 2, 3, 32'h80000000, 1),   32'h0, 2'd1};
        vt[18] = '{mk(0, 7'h20, 0, 5, 6, 7, 32'h12345678, 1),   32'h406283B3, 2'd0};

        repeat (3) @(negedge clk);
        chk("reset_dut1", 64'({mem_we1, in_ready1, busy1, done1, err1, code1, wc1, mem_addr1, wdata1}), 64'd0);
        chk("reset_dut2", 64'({mem_we2, in_ready2, busy2, done2, err2, code2, wc2, mem_addr2, wdata2}), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            pulse(0);
            send(vt[i].d, 0);
            if (vt[i].code == 2'd0) begin
                chk($sformatf("v%0d_we", i), 64'(mem_we1), 64'd1);
                chk($sformatf("v%0d_addr", i), 64'(mem_addr1), 64'd0);
                chk($sformatf("v%0d_wdata", i), 64'(wdata1), 64'(vt[i].word));
                wait_done(0);
                chk($sformatf("v%0d_count", i), 64'(wc1), 64'd1);
                chk($sformatf("v%0d_err", i), 64'(err1), 64'd0);
            end else begin
                chk($sformatf("v%0d_nowrite", i), 64'({mem_we1, done1, err1}), 64'b011);
                chk($sformatf("v%0d_code", i), 64'(code1), 64'(vt[i].code));
                chk($sformatf("v%0d_count", i), 64'(wc1), 64'd0);
            end
        end

        pulse(0);
        for (int i = 1; i <= 4; i++) begin
            d = vt[i].d;
            d.last = (i == 4);
            send(d, 0);
            chk($sformatf("seq%0d_addr", i), 64'(mem_addr1), 64'(i - 1));
            chk($sformatf("seq%0d_wdata", i), 64'(wdata1), 64'(vt[i].word));
        end
        wait_done(0);
        chk("seq_count", 64'(wc1), 64'd4);
        chk("seq_err", 64'(err1), 64'd0);

        mem_ready_man = 1'b0;
        pulse(0);
        d = vt[1].d;
        d.last = 1'b0;
        send(d, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d", k), 64'({mem_we1, in_ready1, mem_addr1, wdata1}),
                64'({1'b1, 1'b0, 8'd0, 32'h00500093}));
        end
        @(negedge clk);
        mem_ready_man = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release", 64'({mem_we1, in_ready1, wc1}), 64'({1'b0, 1'b1, 9'd1}));
        send(vt[0].d, 0);
        chk("stall_next_addr", 64'(mem_addr1), 64'd1);
        chk("stall_next_wdata", 64'(wdata1), 64'h002081B3);
        wait_done(0);
        chk("stall_count", 64'(wc1), 64'd2);

        pulse(0);
        send(vt[9].d, 0);
        chk("err_state", 64'({mem_we1, done1, err1, code1}), 64'({1'b0, 1'b1, 1'b1, 2'd1}));
        pulse(0);
        chk("restart_clear", 64'({err1, code1, mem_addr1, wc1, busy1}), 64'({1'b0, 2'd0, 8'd0, 9'd0, 1'b1}));
        send(vt[0].d, 0);
        wait_done(0);
        chk("restart_count", 64'(wc1), 64'd1);

        rnd_en = 1'b1;
        mon_en = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int n, cnt;
            logic [1:0] ecode;
            n = $urandom_range(1, 6);
            cnt = 0;
            ecode = 2'd0;
            pulse(0);
            for (int i = 0; i < n; i++) begin
                d = gen();
                d.last = (i == n - 1);
                ecode = model_code(d);
                if (ecode == 2'd0) begin
                    exp_addr_q.push_back(cnt);
                    exp_q.push_back(model_word(d));
                    cnt++;
                end
                send(d, 0);
                if (ecode != 2'd0) break;
            end
            wait_done(0);
            chk($sformatf("rnd%0d_err", p), 64'({err1, code1}), 64'({ecode != 2'd0, ecode}));
            chk($sformatf("rnd%0d_count", p), 64'(wc1), 64'(cnt));
            chk($sformatf("rnd%0d_pending", p), 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            exp_addr_q.delete();
        end
        rnd_en = 1'b0;
        mon_en = 1'b0;

        mem_ready_man = 1'b0;
        pulse(0);
        send(vt[1].d, 0);
        chk("pre_reset_busy", 64'({busy1, mem_we1}), 64'b11);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({mem_we1, in_ready1, busy1, done1, err1, code1, wc1, mem_addr1, wdata1}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready_man = 1'b1;

        pulse(1);
        for (int i = 0; i < 4; i++) begin
            d = mk(1, 7'h00, 0, 1, 0, 5'(i + 1), 32'(i * 4), 1'b0);
            send(d, 1);
            chk($sformatf("small%0d_we_addr", i), 64'({mem_we2, mem_addr2}), 64'({1'b1, 2'(i)}));
            chk($sformatf("small%0d_wdata", i), 64'(wdata2), 64'(model_word(d)));
        end
        send(vt[0].d, 1);
        chk("overflow", 64'({mem_we2, done2, err2, code2, wc2, mem_addr2}),
            64'({1'b0, 1'b1, 1'b1, 2'd3, 3'd4, 2'd0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
